cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter PC_WIDTH, default 8, sets the program-counter width in bits.
REQ-002 Parameter PROG_LEN, default 256, sets the number of instruction slots; legal range is 2..2**PC_WIDTH.
REQ-003 Parameter WRAP_EN, default 1: 1 means the PC wraps to 0 after slot PROG_LEN-1; 0 means the block halts after retiring slot PROG_LEN-1.
REQ-004 clk  in  1  the only clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  single-cycle request to begin or restart execution.
REQ-007 stall  in  1  freezes the sequencer while high.
REQ-008 imem_ready  in  1  inst is valid this cycle.
REQ-009 inst  in  8  instruction word from the fetch unit.
REQ-010 pc  out  PC_WIDTH  current instruction address.
REQ-011 ir  out  8  latched instruction register.
REQ-012 fetch_en, decode_en, read_en, exec_en, wb_en  out  1 each  per-stage enable strobes.
REQ-013 busy  out  1  high in every state except IDLE and HALT.
REQ-014 halted  out  1  high in HALT.
REQ-015 retired_cnt  out  16  count of instructions completed through WB.

Function
REQ-016 The FSM states SHALL be IDLE, FETCH, DECODE, READ, EXEC, WB and HALT, one-hot or binary encoded.
REQ-017 IDLE: when start=1, go to FETCH; otherwise stay in IDLE.
REQ-018 FETCH: fetch_en=1; when imem_ready=1, load ir<=inst and go to DECODE; otherwise stay in FETCH with no timeout.
REQ-019 DECODE: decode_en=1 for one cycle; go to HALT if ir==8'hFF, else go to READ.
REQ-020 READ: read_en=1 for one cycle, then go to EXEC.
REQ-021 EXEC: exec_en=1 for one cycle, then go to WB.
REQ-022 WB: wb_en=1 for one cycle; increment retired_cnt, saturating at 16'hFFFF.
REQ-023 WB, pc < PROG_LEN-1: pc<=pc+1 and go to FETCH.
REQ-024 WB, pc == PROG_LEN-1, WRAP_EN=1: pc<=0 and go to FETCH.
REQ-025 WB, pc == PROG_LEN-1, WRAP_EN=0: pc is held and the FSM goes to HALT.
REQ-026 HALT: halted=1; on start=1, clear pc and retired_cnt to 0 and go to FETCH.
REQ-027 start is ignored in FETCH, DECODE, READ, EXEC and WB.
REQ-028 stall=1 in a non-IDLE, non-HALT state holds state, pc, ir and retired_cnt and forces every *_en to 0.
REQ-029 stall takes priority over a simultaneous imem_ready; ir is not loaded that cycle.
REQ-030 Each *_en is decoded from the state register and stall only, so at most one *_en is high per cycle.
REQ-031 Latency: a non-halt instruction takes 5 cycles from FETCH entry to WB exit when imem_ready is high on the first FETCH cycle and stall stays low.
REQ-032 The HALT opcode 8'hFF is not counted in retired_cnt and never asserts read_en, exec_en or wb_en.

Reset
REQ-033 reset=1 overrides all other inputs in the same cycle, including mid-instruction and during stall.
REQ-034 On reset: state=IDLE, pc=0, ir=8'h00, retired_cnt=0, all *_en=0, busy=0, halted=0.

Structure
REQ-035 A shared package cpu_pkg holds the state enumeration, the HALT_OPCODE constant (8'hFF) and the stage count (5).
REQ-036 One sub-module, retire_counter, implements the 16-bit saturating counter with sync clear and increment enable.
REQ-037 pc, ir and state are registers in cpu_sequencer; no latches and no combinational loops through imem_ready.

Verification
REQ-038 Reset, then start with inst=8'h1B and imem_ready=1 held -> enables sequence fetch, decode, read, exec, wb over 5 cycles; pc=1; retired_cnt=1.
REQ-039 imem_ready held low for 3 cycles in FETCH, then high -> fetch_en high for 4 cycles; ir captures inst on the 4th cycle.
REQ-040 stall=1 for 2 cycles during EXEC -> exec_en=0 in those cycles, state held; exec_en=1 the cycle after stall drops; only one wb_en pulse.
REQ-041 inst=8'hFF fetched at pc=3 -> HALT after DECODE, halted=1, pc=3, retired_cnt unchanged; then start -> pc=0, retired_cnt=0, FETCH.
REQ-042 PROG_LEN=4: WRAP_EN=1 gives pc sequence 0,1,2,3,0; WRAP_EN=0 gives halted=1 after the 4th WB with retired_cnt=4.
REQ-043 reset asserted in READ together with stall=1 -> next cycle all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction sequencer.
package cpu_pkg;

  // The sequencer steps through these states in order for each instruction.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_READ   = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  // Opcode that stops execution at DECODE without being retired.
  localparam logic [7:0] HALT_OPCODE = 8'hFF;

  // Pipeline stages an ordinary instruction passes through.
  localparam int unsigned NUM_STAGES = 5;

  // True in states where the sequencer is executing and stall applies.
  function automatic logic is_active(input state_t s);
    return (s != ST_IDLE) && (s != ST_HALT);
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Saturating retired-instruction counter with synchronous clear.
module retire_counter
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Clear wins over increment; increment stops at the all-ones value.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/READ/EXEC/WB with halt,
// stall and optional PC wrap at the end of the program.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 8,
  parameter int unsigned PROG_LEN = 256,
  parameter bit          WRAP_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stall,
  input  logic                imem_ready,
  input  logic [7:0]          inst,
  output logic [PC_WIDTH-1:0] pc,
  output logic [7:0]          ir,
  output logic                fetch_en,
  output logic                decode_en,
  output logic                read_en,
  output logic                exec_en,
  output logic                wb_en,
  output logic                busy,
  output logic                halted,
  output logic [15:0]         retired_cnt
);

  localparam logic [PC_WIDTH-1:0] LAST_PC = PC_WIDTH'(PROG_LEN - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [7:0]          r_ir;
  logic [7:0]          w_ir_next;
  logic                w_cnt_clr;
  logic                w_cnt_inc;
  logic                w_hold;

  // A stall only freezes the machine while it is actually executing.
  assign w_hold = is_active(r_state) && stall;

  // State, PC and instruction register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_pc    <= '0;
      r_ir    <= 8'h00;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
    end
  end

  // Next-state, PC/IR update and counter control.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    if (!w_hold) begin
      case (r_state)
        ST_IDLE: begin
          if (start) w_state_next = ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ready) begin
            w_ir_next    = inst;
            w_state_next = ST_DECODE;
          end
        end
        ST_DECODE: begin
          w_state_next = (r_ir == HALT_OPCODE) ? ST_HALT : ST_READ;
        end
        ST_READ: w_state_next = ST_EXEC;
        ST_EXEC: w_state_next = ST_WB;
        ST_WB: begin
          w_cnt_inc = 1'b1;
          if (r_pc == LAST_PC) begin
            if (WRAP_EN) begin
              w_pc_next    = '0;
              w_state_next = ST_FETCH;
            end else begin
              w_state_next = ST_HALT;
            end
          end else begin
            w_pc_next    = r_pc + PC_WIDTH'(1);
            w_state_next = ST_FETCH;
          end
        end
        ST_HALT: begin
          if (start) begin
            w_pc_next    = '0;
            w_cnt_clr    = 1'b1;
            w_state_next = ST_FETCH;
          end
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  retire_counter #(
    .WIDTH (16)
  ) u_retire_counter (
    .clk     (clk),
    .reset   (reset),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .o_count (retired_cnt)
  );

  // Stage strobes depend only on the state register and stall.
  assign fetch_en  = (r_state == ST_FETCH)  && !stall;
  assign decode_en = (r_state == ST_DECODE) && !stall;
  assign read_en   = (r_state == ST_READ)   && !stall;
  assign exec_en   = (r_state == ST_EXEC)   && !stall;
  assign wb_en     = (r_state == ST_WB)     && !stall;

  assign busy   = is_active(r_state);
  assign halted = (r_state == ST_HALT);
  assign pc     = r_pc;
  assign ir     = r_ir;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed testbench for cpu_sequencer: default build plus two PROG_LEN=4
// builds (wrapping and halting) driven from the same inputs.
module tb_cpu_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stall;
  logic        imem_ready;
  logic [7:0]  inst;

  logic [7:0]  pc, ir;
  logic        fetch_en, decode_en, read_en, exec_en, wb_en, busy, halted;
  logic [15:0] retired_cnt;

  logic [1:0]  w4_pc, h4_pc;
  logic [7:0]  w4_ir, h4_ir;
  logic        w4_fe, w4_de, w4_re, w4_ee, w4_we, w4_busy, w4_halted;
  logic        h4_fe, h4_de, h4_re, h4_ee, h4_we, h4_busy, h4_halted;
  logic [15:0] w4_cnt, h4_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  wire [4:0] en = {fetch_en, decode_en, read_en, exec_en, wb_en};

  cpu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .imem_ready(imem_ready), .inst(inst),
    .pc(pc), .ir(ir), .fetch_en(fetch_en), .decode_en(decode_en),
    .read_en(read_en), .exec_en(exec_en), .wb_en(wb_en),
    .busy(busy), .halted(halted), .retired_cnt(retired_cnt)
  );

  cpu_sequencer #(.PC_WIDTH(2), .PROG_LEN(4), .WRAP_EN(1'b1)) dut_wrap (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .imem_ready(imem_ready), .inst(inst),
    .pc(w4_pc), .ir(w4_ir), .fetch_en(w4_fe), .decode_en(w4_de),
    .read_en(w4_re), .exec_en(w4_ee), .wb_en(w4_we),
    .busy(w4_busy), .halted(w4_halted), .retired_cnt(w4_cnt)
  );

  cpu_sequencer #(.PC_WIDTH(2), .PROG_LEN(4), .WRAP_EN(1'b0)) dut_halt (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .imem_ready(imem_ready), .inst(inst),
    .pc(h4_pc), .ir(h4_ir), .fetch_en(h4_fe), .decode_en(h4_de),
    .read_en(h4_re), .exec_en(h4_ee), .wb_en(h4_we),
    .busy(h4_busy), .halted(h4_halted), .retired_cnt(h4_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs may be changed afterwards, then settle() before checks.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stall = 1'b0; imem_ready = 1'b0; inst = 8'h00;
    cyc();
    reset = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (en !== 5'b0) begin n_fail++; $display("FAIL reset_en got=%b exp=%b", en, 5'b0); end
    n_tests++;
    if ({busy, halted} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b exp=00", {busy, halted}); end
    n_tests++;
    if (pc !== 8'd0 || ir !== 8'h00 || retired_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_regs pc=%0d ir=%h cnt=%0d exp 0/00/0", pc, ir, retired_cnt);
    end
    cyc(); settle();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold busy=%b exp=0", busy); end
    $display("[TB] reset: pc=%0d ir=%h cnt=%0d en=%b", pc, ir, retired_cnt, en);
  endtask

  task automatic test_basic();
    logic [4:0] exp_en [5];
    exp_en[0] = 5'b10000; exp_en[1] = 5'b01000; exp_en[2] = 5'b00100;
    exp_en[3] = 5'b00010; exp_en[4] = 5'b00001;
    do_reset();
    inst = 8'h1B; imem_ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    settle();
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (en !== exp_en[k] || busy !== 1'b1) begin
        n_fail++; $display("FAIL basic_stage%0d en=%b busy=%b exp en=%b busy=1", k, en, busy, exp_en[k]);
      end
      if (k < 4) begin cyc(); settle(); end
    end
    cyc();
    imem_ready = 1'b0;
    settle();
    n_tests++;
    if (pc !== 8'd1 || retired_cnt !== 16'd1 || ir !== 8'h1B || en !== 5'b10000) begin
      n_fail++; $display("FAIL basic_end pc=%0d cnt=%0d ir=%h en=%b exp 1/1/1b/10000", pc, retired_cnt, ir, en);
    end
    $display("[TB] basic: pc=%0d cnt=%0d ir=%h", pc, retired_cnt, ir);
  endtask

  task automatic test_imem_wait();
    do_reset();
    inst = 8'h33; imem_ready = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    settle();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (fetch_en !== 1'b1 || ir !== 8'h00) begin
        n_fail++; $display("FAIL wait_cycle%0d fetch_en=%b ir=%h exp 1/00", k, fetch_en, ir);
      end
      cyc(); settle();
    end
    inst = 8'h5A; imem_ready = 1'b1;
    settle();
    n_tests++;
    if (fetch_en !== 1'b1) begin n_fail++; $display("FAIL wait_cycle3 fetch_en=%b exp 1", fetch_en); end
    cyc();
    imem_ready = 1'b0;
    settle();
    n_tests++;
    if (ir !== 8'h5A || en !== 5'b01000) begin
      n_fail++; $display("FAIL wait_capture ir=%h en=%b exp 5a/01000", ir, en);
    end
    $display("[TB] imem_wait: ir=%h en=%b", ir, en);
  endtask

  // Continues from DECODE left by test_imem_wait.
  task automatic test_stall();
    int wb_pulses;
    wb_pulses = 0;
    cyc(); cyc(); settle();
    n_tests++;
    if (en !== 5'b00010) begin n_fail++; $display("FAIL stall_pre en=%b exp 00010", en); end
    stall = 1'b1;
    settle();
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (en !== 5'b00000 || busy !== 1'b1) begin
        n_fail++; $display("FAIL stall_cycle%0d en=%b busy=%b exp 00000/1", k, en, busy);
      end
      cyc(); settle();
    end
    stall = 1'b0;
    settle();
    n_tests++;
    if (en !== 5'b00010) begin n_fail++; $display("FAIL stall_resume en=%b exp 00010", en); end
    for (int k = 0; k < 5; k++) begin
      cyc(); settle();
      if (wb_en === 1'b1) wb_pulses++;
    end
    n_tests++;
    if (wb_pulses != 1 || retired_cnt !== 16'd1 || pc !== 8'd1) begin
      n_fail++; $display("FAIL stall_wb pulses=%0d cnt=%0d pc=%0d exp 1/1/1", wb_pulses, retired_cnt, pc);
    end
    // Now waiting in FETCH; stall must block a simultaneous imem_ready.
    stall = 1'b1; imem_ready = 1'b1; inst = 8'h77;
    settle();
    n_tests++;
    if (fetch_en !== 1'b0) begin n_fail++; $display("FAIL stall_fetch_en fetch_en=%b exp 0", fetch_en); end
    cyc();
    stall = 1'b0; imem_ready = 1'b0;
    settle();
    n_tests++;
    if (fetch_en !== 1'b1 || ir !== 8'h5A) begin
      n_fail++; $display("FAIL stall_priority fetch_en=%b ir=%h exp 1/5a", fetch_en, ir);
    end
    $display("[TB] stall: wb_pulses=%0d cnt=%0d ir=%h", wb_pulses, retired_cnt, ir);
  endtask

  task automatic test_halt();
    do_reset();
    inst = 8'h01; imem_ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (15) cyc();
    inst = 8'hFF;
    settle();
    n_tests++;
    if (pc !== 8'd3 || retired_cnt !== 16'd3 || fetch_en !== 1'b1) begin
      n_fail++; $display("FAIL halt_pre pc=%0d cnt=%0d fetch_en=%b exp 3/3/1", pc, retired_cnt, fetch_en);
    end
    cyc(); settle();
    n_tests++;
    if (en !== 5'b01000 || ir !== 8'hFF) begin n_fail++; $display("FAIL halt_decode en=%b ir=%h exp 01000/ff", en, ir); end
    cyc(); settle();
    n_tests++;
    if (halted !== 1'b1 || busy !== 1'b0 || en !== 5'b0 || pc !== 8'd3 || retired_cnt !== 16'd3) begin
      n_fail++; $display("FAIL halt_state halted=%b busy=%b en=%b pc=%0d cnt=%0d exp 1/0/00000/3/3",
                         halted, busy, en, pc, retired_cnt);
    end
    cyc(); settle();
    n_tests++;
    if (halted !== 1'b1 || en !== 5'b0) begin n_fail++; $display("FAIL halt_hold halted=%b en=%b exp 1/00000", halted, en); end
    start = 1'b1;
    cyc();
    start = 1'b0; imem_ready = 1'b0;
    settle();
    n_tests++;
    if (pc !== 8'd0 || retired_cnt !== 16'd0 || halted !== 1'b0 || fetch_en !== 1'b1) begin
      n_fail++; $display("FAIL halt_restart pc=%0d cnt=%0d halted=%b fetch_en=%b exp 0/0/0/1",
                         pc, retired_cnt, halted, fetch_en);
    end
    $display("[TB] halt: restarted pc=%0d cnt=%0d", pc, retired_cnt);
  endtask

  task automatic test_wrap();
    logic [1:0] exp_pc [5];
    exp_pc[0] = 2'd0; exp_pc[1] = 2'd1; exp_pc[2] = 2'd2; exp_pc[3] = 2'd3; exp_pc[4] = 2'd0;
    do_reset();
    inst = 8'h01; imem_ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    settle();
    for (int k = 0; k < 5; k++) begin
      n_tests++;
      if (w4_pc !== exp_pc[k] || w4_fe !== 1'b1) begin
        n_fail++; $display("FAIL wrap_pc%0d pc=%0d fetch_en=%b exp %0d/1", k, w4_pc, w4_fe, exp_pc[k]);
      end
      if (k < 4) begin repeat (5) cyc(); settle(); end
    end
    n_tests++;
    if (h4_halted !== 1'b1 || h4_cnt !== 16'd4 || h4_pc !== 2'd3 || h4_busy !== 1'b0) begin
      n_fail++; $display("FAIL nowrap_halt halted=%b cnt=%0d pc=%0d busy=%b exp 1/4/3/0",
                         h4_halted, h4_cnt, h4_pc, h4_busy);
    end
    n_tests++;
    if (w4_cnt !== 16'd4 || w4_halted !== 1'b0) begin
      n_fail++; $display("FAIL wrap_cnt cnt=%0d halted=%b exp 4/0", w4_cnt, w4_halted);
    end
    $display("[TB] wrap: wrap_pc=%0d nowrap_halted=%b nowrap_cnt=%0d", w4_pc, h4_halted, h4_cnt);
  endtask

  task automatic test_reset_mid();
    do_reset();
    inst = 8'h01; imem_ready = 1'b1; start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (7) cyc();
    settle();
    n_tests++;
    if (read_en !== 1'b1 || pc !== 8'd1 || retired_cnt !== 16'd1) begin
      n_fail++; $display("FAIL rstmid_pre read_en=%b pc=%0d cnt=%0d exp 1/1/1", read_en, pc, retired_cnt);
    end
    reset = 1'b1; stall = 1'b1;
    cyc();
    reset = 1'b0; imem_ready = 1'b0;
    settle();
    n_tests++;
    if (en !== 5'b0 || busy !== 1'b0 || halted !== 1'b0 || pc !== 8'd0 || ir !== 8'h00 || retired_cnt !== 16'd0) begin
      n_fail++; $display("FAIL rstmid_state en=%b busy=%b halted=%b pc=%0d ir=%h cnt=%0d exp all 0",
                         en, busy, halted, pc, ir, retired_cnt);
    end
    stall = 1'b0;
    cyc(); settle();
    n_tests++;
    if (busy !== 1'b0 || fetch_en !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_idle busy=%b fetch_en=%b exp 0/0", busy, fetch_en);
    end
    $display("[TB] reset_mid: busy=%b pc=%0d cnt=%0d", busy, pc, retired_cnt);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; imem_ready = 1'b0; inst = 8'h00;
    test_reset();
    test_basic();
    test_imem_wait();
    test_stall();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
